// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request at a time, IF/ID slot with
// valid/ready handshake, PC next-value selection, redirect flush and misaligned-PC faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_fault
);

  typedef enum logic [1:0] {SReq, SWait, SHold, SFault} state_e;

  state_e      state_q;
  logic        drop_q;
  logic        fault_sent_q;
  logic [31:0] req_pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_fault_q;

  logic misaligned;
  logic slot_free;
  logic req_valid;
  logic req_fire;

  assign misaligned = (pc[1:0] != 2'b00);
  assign slot_free  = !ifid_valid_q || ifid_ready;
  assign req_valid  = !rst && (state_q == SReq) && !misaligned && !redirect_valid;
  assign req_fire   = req_valid && imem_req_ready;

  always_comb begin
    pc_next = pc;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (req_fire) begin
      pc_next = pc + 32'd4;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_fault     = ifid_fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // A request still in flight keeps the FSM waiting so its late response is swallowed.
      if (state_q == SWait && !imem_rsp_valid) begin
        state_q <= SWait;
        drop_q  <= 1'b1;
      end else begin
        state_q <= SReq;
        drop_q  <= 1'b0;
      end
      fault_sent_q <= 1'b0;
      req_pc_q     <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_fault_q <= 1'b0;
    end else begin
      if (ifid_ready) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
        ifid_fault_q <= 1'b0;
      end

      if (redirect_valid) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
        ifid_fault_q <= 1'b0;
        fault_sent_q <= 1'b0;
        if (state_q == SWait && !imem_rsp_valid) begin
          state_q <= SWait;
          drop_q  <= 1'b1;
        end else begin
          state_q <= SReq;
          drop_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          SReq: begin
            if (misaligned) begin
              state_q      <= SFault;
              fault_sent_q <= 1'b0;
            end else if (req_fire) begin
              req_pc_q <= pc;
              drop_q   <= 1'b0;
              state_q  <= SWait;
            end
          end
          SWait: begin
            if (imem_rsp_valid) begin
              if (drop_q) begin
                state_q <= SReq;
              end else if (slot_free) begin
                ifid_valid_q <= 1'b1;
                ifid_pc_q    <= req_pc_q;
                ifid_instr_q <= imem_rsp_data;
                ifid_fault_q <= 1'b0;
                state_q      <= SReq;
              end else begin
                hold_pc_q    <= req_pc_q;
                hold_instr_q <= imem_rsp_data;
                state_q      <= SHold;
              end
            end
          end
          SHold: begin
            if (slot_free) begin
              ifid_valid_q <= 1'b1;
              ifid_pc_q    <= hold_pc_q;
              ifid_instr_q <= hold_instr_q;
              ifid_fault_q <= 1'b0;
              state_q      <= SReq;
            end
          end
          SFault: begin
            // Fault entry goes out once; the FSM then parks until a redirect.
            if (slot_free && !fault_sent_q) begin
              ifid_valid_q <= 1'b1;
              ifid_pc_q    <= pc;
              ifid_instr_q <= NOP_INSTR;
              ifid_fault_q <= 1'b1;
              fault_sent_q <= 1'b1;
            end
          end
          default: state_q <= SReq;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus an
// abstract per-cycle model (outstanding/pending/fault bookkeeping) checked every cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        ifid_valid;
  logic        ifid_ready = 1'b1;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .pc_next       (pc_next),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .ifid_valid    (ifid_valid),
    .ifid_ready    (ifid_ready),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_fault    (ifid_fault)
  );

  always #5 clk = ~clk;

  // PC register downstream of pc_next
  always @(posedge clk) begin
    pc  <= pc_next;
    cyc <= cyc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hAAAA_0001;
      32'h0000_0004: return 32'hAAAA_0002;
      32'h0000_0008: return 32'hAAAA_0003;
      32'h0000_0010: return 32'hBEEF_0000;
      default:       return a ^ 32'h5EED_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: answers mem_lat cycles after an accepted request; never back-pressured.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
        end
      end
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        mem_cnt  = mem_lat;
        mem_addr = imem_addr;
      end
    end
  end

  // Behavioural model: state after the coming edge is computed at each negedge.
  bit          m_busy = 0, m_stale = 0, m_pend_v = 0, m_fmode = 0, m_fsent = 0;
  bit          m_sv = 0, m_sf = 0;
  logic [31:0] m_opc = 0, m_ppc = 0, m_pinstr = 0, m_spc = 0, m_sinstr = 0;

  initial begin
    bit          idle, e_req, e_acc, free;
    logic [31:0] e_next;
    forever begin
      @(negedge clk);
      idle   = !m_busy && !m_pend_v && !m_fmode;
      e_req  = !rst && idle && (pc[1:0] == 2'b00) && !redirect_valid;
      e_acc  = e_req && imem_req_ready;
      e_next = rst ? 32'h0 : redirect_valid ? redirect_pc : e_acc ? pc + 32'd4 : pc;
      chk("model pc_next", pc_next, e_next);
      chk("model imem_req_valid", imem_req_valid, e_req);
      if (e_req) chk("model imem_addr", imem_addr, pc);
      chk("model ifid_valid", ifid_valid, m_sv);
      if (m_sv && ifid_valid) begin
        chk("model ifid_pc", ifid_pc, m_spc);
        chk("model ifid_instr", ifid_instr, m_sinstr);
        chk("model ifid_fault", ifid_fault, m_sf);
      end
      free = !m_sv || ifid_ready;
      if (rst) begin
        m_sv = 0; m_pend_v = 0; m_fmode = 0;
        if (m_busy) begin
          if (imem_rsp_valid) m_busy = 0;
          else m_stale = 1;
        end
      end else begin
        if (ifid_ready) m_sv = 0;
        if (redirect_valid) begin
          m_sv = 0; m_pend_v = 0; m_fmode = 0;
          if (m_busy) begin
            if (imem_rsp_valid) m_busy = 0;
            else m_stale = 1;
          end
        end else begin
          if (m_busy && imem_rsp_valid) begin
            m_busy = 0;
            if (!m_stale) begin
              if (free) begin
                m_sv = 1; m_spc = m_opc; m_sinstr = imem_rsp_data; m_sf = 0;
              end else begin
                m_pend_v = 1; m_ppc = m_opc; m_pinstr = imem_rsp_data;
              end
            end
          end else if (m_pend_v) begin
            if (free) begin
              m_sv = 1; m_spc = m_ppc; m_sinstr = m_pinstr; m_sf = 0; m_pend_v = 0;
            end
          end else if (m_fmode) begin
            if (free && !m_fsent) begin
              m_sv = 1; m_spc = pc; m_sinstr = NOP; m_sf = 1; m_fsent = 1;
            end
          end else if (!m_busy && pc[1:0] != 2'b00) begin
            m_fmode = 1; m_fsent = 0;
          end
          if (e_acc) begin
            m_busy = 1; m_opc = pc; m_stale = 0;
          end
        end
      end
    end
  end

  // Both wait tasks are entered at a negedge and check the current cycle first.
  task automatic expect_slot(input string name, input logic [31:0] epc, input logic [31:0] einstr,
                             input logic efault, output int at);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifid_valid && ifid_pc == epc) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    at = cyc;
    chk({name, " presented"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      chk({name, " instr"}, ifid_instr, einstr);
      chk({name, " fault"}, {31'b0, ifid_fault}, {31'b0, efault});
    end
  endtask

  task automatic expect_accept(input string name, input logic [31:0] eaddr,
                               input logic [31:0] enext);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req_valid && imem_req_ready) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk({name, " accepted"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      chk({name, " addr"}, imem_addr, eaddr);
      chk({name, " pc_next"}, pc_next, enext);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1, c2, c;
    int nf, nreq, nv, nacc;
    logic [31:0] fpc, finstr, acc_addr;

    @(negedge clk);
    chk("reset ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("reset ifid_pc", ifid_pc, 32'h0);
    chk("reset ifid_instr", ifid_instr, 32'h0000_0013);
    chk("reset ifid_fault", {31'b0, ifid_fault}, 32'd0);
    chk("reset pc_next", pc_next, 32'h0);
    chk("reset imem_req_valid", {31'b0, imem_req_valid}, 32'd0);
    next_drive();
    rst = 1'b0;
    @(negedge clk);

    // Sequential fetch, 1-cycle memory
    expect_accept("t1 acc 0", 32'h0, 32'h4);
    expect_slot("t1 slot 0", 32'h0, 32'hAAAA_0001, 1'b0, c0);
    expect_accept("t1 acc 4", 32'h4, 32'h8);
    expect_slot("t1 slot 4", 32'h4, 32'hAAAA_0002, 1'b0, c1);
    expect_accept("t1 acc 8", 32'h8, 32'hC);
    expect_slot("t1 slot 8", 32'h8, 32'hAAAA_0003, 1'b0, c2);
    chk("t1 spacing a", c1 - c0, 32'd2);
    chk("t1 spacing b", c2 - c1, 32'd2);

    // Decode stall while the 0x10 response lands
    next_drive();
    ifid_ready = 1'b0;
    @(negedge clk);
    expect_slot("t2 slot c", 32'hC, 32'h5EED_000C, 1'b0, c);
    repeat (2) @(negedge clk);
    chk("t2 hold no req", {31'b0, imem_req_valid}, 32'd0);
    chk("t2 hold pc_next", pc_next, 32'h14);
    chk("t2 hold slot pc", ifid_pc, 32'hC);
    next_drive();
    ifid_ready = 1'b1;
    @(negedge clk);
    expect_slot("t2 slot 10", 32'h10, 32'hBEEF_0000, 1'b0, c);
    expect_accept("t2 acc 14", 32'h14, 32'h18);

    // Redirect while the 0x20 request is outstanding
    expect_slot("t3 slot 14", 32'h14, 32'h5EED_0014, 1'b0, c);
    expect_accept("t3 acc 18", 32'h18, 32'h1C);
    expect_slot("t3 slot 18", 32'h18, 32'h5EED_0018, 1'b0, c);
    next_drive();
    mem_lat = 3;
    @(negedge clk);
    expect_accept("t3 acc 20", 32'h20, 32'h24);
    next_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("t3 redirect pc_next", pc_next, 32'h100);
    next_drive();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3 flushed ifid_valid", {31'b0, ifid_valid}, 32'd0);
    expect_accept("t3 acc 100", 32'h100, 32'h104);
    expect_slot("t3 slot 100", 32'h100, 32'h5EED_0100, 1'b0, c);

    // Misaligned redirect target
    next_drive();
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    next_drive();
    redirect_valid = 1'b0;
    nf = 0; nreq = 0; fpc = 0; finstr = 0;
    repeat (12) begin
      @(negedge clk);
      if (imem_req_valid) nreq++;
      if (ifid_valid && ifid_fault) begin
        nf++;
        fpc    = ifid_pc;
        finstr = ifid_instr;
      end
    end
    chk("t4 fault count", nf, 32'd1);
    chk("t4 fault pc", fpc, 32'h102);
    chk("t4 fault instr", finstr, 32'h0000_0013);
    chk("t4 no requests", nreq, 32'd0);
    chk("t4 pc held", pc, 32'h102);
    chk("t4 pc_next held", pc_next, 32'h102);
    next_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    next_drive();
    redirect_valid = 1'b0;
    @(negedge clk);
    expect_accept("t4 acc 200", 32'h200, 32'h204);
    expect_slot("t4 slot 200", 32'h200, 32'h5EED_0200, 1'b0, c);

    // Back-pressure at the top of the address space
    next_drive();
    imem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    next_drive();
    redirect_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5 stalled req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t5 stalled pc_next", pc_next, 32'hFFFF_FFFC);
    end
    next_drive();
    imem_req_ready = 1'b1;
    @(negedge clk);
    expect_accept("t5 acc wrap", 32'hFFFF_FFFC, 32'h0);

    // Reset while a slow response is outstanding
    next_drive();
    mem_lat = 4;
    @(negedge clk);
    expect_slot("t5 slot wrap", 32'hFFFF_FFFC, 32'hA112_FFFC, 1'b0, c);
    expect_accept("t6 acc 0 pre", 32'h0, 32'h4);
    next_drive();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t6 rst pc_next", pc_next, 32'h0);
      chk("t6 rst req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("t6 rst ifid_valid", {31'b0, ifid_valid}, 32'd0);
      next_drive();
    end
    rst = 1'b0;
    nv = 0; nacc = 0; acc_addr = 32'hDEAD_BEEF;
    repeat (6) begin
      @(negedge clk);
      if (ifid_valid) nv++;
      if (imem_req_valid && imem_req_ready) begin
        nacc++;
        acc_addr = imem_addr;
      end
    end
    chk("t6 stale dropped", nv, 32'd0);
    chk("t6 one fetch", nacc, 32'd1);
    chk("t6 first fetch addr", acc_addr, 32'h0);
    expect_slot("t6 slot 0", 32'h0, 32'hAAAA_0001, 1'b0, c);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 32-bit RISC core, directly downstream of the program counter register.
- Takes the current PC, issues one instruction-memory request at a time and captures the returned word into the IF/ID pipeline slot with a valid/ready handshake.
- Drives the PC register's next-value input: hold, PC+4 or branch/jump redirect.
- Handles decode stalls, redirect flushes and misaligned-PC faults.

Parameters:
- RESET_PC, 32'h00000000, PC value during reset; equals the PC register reset value.
- NOP_INSTR, 32'h00000013, instruction placed in the IF/ID slot when empty or faulted (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC from the PC register output.
- pc_next  out  32  next PC to the PC register input; combinational.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  instruction-memory request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  request address; equals pc.
- imem_rsp_valid  in  1  response valid; the memory cannot be back-pressured.
- imem_rsp_data  in  32  returned instruction word.
- ifid_valid  out  1  IF/ID slot holds an instruction.
- ifid_ready  in  1  decode consumes the slot this cycle.
- ifid_pc  out  32  PC of the slot instruction.
- ifid_instr  out  32  slot instruction.
- ifid_fault  out  1  slot is a misaligned-fetch fault entry.

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_FAULT. Reset enters S_REQ.
- Reset values:
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_fault=0.
  - drop flag=0, req_pc=0, hold buffer=0.
  - pc_next=RESET_PC and imem_req_valid=0 while rst is high.
- Slot-free condition: `slot_free = !ifid_valid || ifid_ready`. A slot load happens only when slot_free is true. If ifid_ready is high and nothing loads, ifid_valid clears.
- pc_next priority:
  1. redirect_valid → redirect_pc.
  2. Request accepted this cycle → pc+4, with 32-bit wrap (32'hFFFFFFFC+4 = 0).
  3. Otherwise → pc (hold).
- S_REQ:
  - If pc[1:0]!=0 and no redirect: go to S_FAULT, hold pc.
  - Else drive imem_req_valid = !redirect_valid and imem_addr=pc.
  - On valid&&ready: latch req_pc=pc, clear drop, go to S_WAIT.
- S_WAIT:
  - On imem_rsp_valid with drop=1: discard the word, go to S_REQ.
  - On imem_rsp_valid with drop=0 and slot_free: load the slot (valid=1, pc=req_pc, instr=rsp_data, fault=0), go to S_REQ.
  - On imem_rsp_valid with drop=0 and slot not free: store {req_pc, data} in the hold buffer, go to S_HOLD.
- S_HOLD: no request issued; pc is held. When slot_free, load the slot from the buffer and go to S_REQ.
- S_FAULT:
  - When slot_free, load the slot (valid=1, pc=pc, instr=NOP_INSTR, fault=1).
  - Stay in S_FAULT, issue no requests and hold pc until a redirect.
  - A fault entry is loaded at most once.
- Redirect (any state), registered effects at the next edge:
  - ifid_valid=0 and the hold buffer is discarded.
  - From S_WAIT: stay in S_WAIT with drop=1, unless the response arrives in the same cycle, in which case it is discarded and the state goes to S_REQ.
  - From S_REQ, S_HOLD or S_FAULT: go to S_REQ.
  - Redirect wins over a simultaneous slot load or response.
- Latency and throughput:
  - At most 1 outstanding request.
  - The word appears on ifid one cycle after imem_rsp_valid.
  - With 1-cycle memory, one instruction every 2 cycles.
- Reset mid-operation: an outstanding response arriving after reset deasserts must be ignored, so reset sets drop=1 if the state was S_WAIT. Otherwise all state takes the reset values above.

Test Plan:
1. Sequential fetch, ready=1, 1-cycle response, ifid_ready=1:
   - Stimulus: after reset, memory returns 0xAAAA0001, 0xAAAA0002, 0xAAAA0003.
   - Required: ifid shows (pc 0x0, 0xAAAA0001), (pc 0x4, 0xAAAA0002), (pc 0x8, 0xAAAA0003), one every 2 cycles; pc_next = 0x4, 0x8, 0xC on the accept cycles.
2. Decode stall:
   - Stimulus: ifid_ready=0 with slot full; response 0xBEEF0000 for pc 0x10 arrives.
   - Required: state S_HOLD, no imem_req_valid, pc_next=pc. After ifid_ready=1, the next slot becomes (0x10, 0xBEEF0000), then the request for 0x14 issues.
3. Redirect during S_WAIT:
   - Stimulus: redirect_valid with redirect_pc=0x100 while the request for 0x20 is outstanding; response arrives 2 cycles later.
   - Required: pc_next=0x100; ifid_valid=0 next cycle; the stale word is never presented; the first slot after that is pc 0x100.
4. Misaligned PC:
   - Stimulus: redirect_pc=0x102.
   - Required: no memory request; slot (pc 0x102, 0x00000013, fault=1) presented exactly once; pc held at 0x102. A redirect to 0x200 resumes fetch at 0x200.
5. Memory back-pressure and wrap:
   - Stimulus: imem_req_ready=0 for 3 cycles with pc=0xFFFFFFFC.
   - Required: imem_req_valid stays 1 and pc_next stays 0xFFFFFFFC; after acceptance pc_next=0x00000000.
6. Reset mid-fetch:
   - Stimulus: rst asserted in S_WAIT, late response arrives after rst falls.
   - Required: response dropped, ifid_valid=0, pc_next=RESET_PC during rst, first fetch is at 0x0.
